sha_pad: RTL and testbench

SHA_PAD -- requirements
Module: sha_pad

---
 rtl/sha_pad_pkg.sv | 15 +
 rtl/sha_pad.sv | 212 +++++++++++++++++++++
 tb/tb_sha_pad.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_pad_pkg.sv
// Shared constants and FSM state type for the SHA-224/256 message padder.
package sha_const;

    localparam int         BLOCK_WORDS = 16;
    localparam int         LEN_WORD    = 14;
    localparam logic [7:0] PAD_BYTE    = 8'h80;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_PAD  = 2'd1,
        S_LEN  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/sha_pad.sv
// SHA-224/256 message padder: packs 32-bit words into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit bit length.
module sha_pad
    import sha_const::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  in_data,
    input  logic [2:0]   in_bytes,
    input  logic         in_last,
    input  logic         in_op,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [511:0] Data,
    output logic [63:0]  Index,
    output logic         Operation,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready
);

    // Keep the valid leading bytes; on the last word put 0x80 right after them.
    function automatic logic [31:0] f_pad_word(input logic [31:0] data,
                                               input logic [2:0]  nbytes,
                                               input logic        last);
        logic [31:0] v;
        v = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (b < 32'(nbytes)) begin
                v[31-8*b -: 8] = data[31-8*b -: 8];
            end else if (last && (b == 32'(nbytes))) begin
                v[31-8*b -: 8] = PAD_BYTE;
            end else begin
                v[31-8*b -: 8] = 8'h00;
            end
        end
        return v;
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  r_wp;
    logic [31:0] r_buf [BLOCK_WORDS];
    logic [63:0] r_len;
    logic [63:0] r_index;
    logic        r_op;
    logic        r_pend80;
    logic        r_padding;
    logic        r_in_msg;
    logic        r_out_last;
    logic        r_out_valid;
    logic        r_in_ready;
    logic        w_in_fire;
    logic        w_out_fire;

    assign w_in_fire  = r_in_ready & in_valid;
    assign w_out_fire = r_out_valid & out_ready;

    // Next-state decode; wp may reach 16 when the block fills during the last word.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_in_fire) begin
                    if (in_last) begin
                        w_next_state = S_PAD;
                    end else if (r_wp == 5'(BLOCK_WORDS - 1)) begin
                        w_next_state = S_OUT;
                    end else begin
                        w_next_state = S_LOAD;
                    end
                end else begin
                    w_next_state = S_LOAD;
                end
            end
            S_PAD: begin
                if (r_pend80) begin
                    if (r_wp == 5'(BLOCK_WORDS)) begin
                        w_next_state = S_OUT;
                    end else begin
                        w_next_state = S_PAD;
                    end
                end else if (r_wp == 5'(LEN_WORD)) begin
                    w_next_state = S_LEN;
                end else if (r_wp < 5'(LEN_WORD)) begin
                    w_next_state = S_PAD;
                end else begin
                    w_next_state = S_OUT;
                end
            end
            S_LEN: begin
                w_next_state = S_OUT;
            end
            S_OUT: begin
                if (w_out_fire) begin
                    if (r_out_last) begin
                        w_next_state = S_LOAD;
                    end else if (r_padding) begin
                        w_next_state = S_PAD;
                    end else begin
                        w_next_state = S_LOAD;
                    end
                end else begin
                    w_next_state = S_OUT;
                end
            end
            default: begin
                w_next_state = S_LOAD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Block buffer, counters and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                r_buf[i] <= 32'h0;
            end
            r_wp        <= 5'd0;
            r_len       <= 64'd0;
            r_index     <= 64'd0;
            r_op        <= 1'b0;
            r_pend80    <= 1'b0;
            r_padding   <= 1'b0;
            r_in_msg    <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_out_valid <= (w_next_state == S_OUT);
            r_in_ready  <= (w_next_state == S_LOAD);
            case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_buf[r_wp[3:0]] <= f_pad_word(in_data, in_bytes, in_last);
                        r_wp             <= r_wp + 5'd1;
                        r_len            <= r_len + {58'd0, in_bytes, 3'd0};
                        r_in_msg         <= 1'b1;
                        if (!r_in_msg) begin
                            r_op <= in_op;
                        end
                        if (in_last) begin
                            r_pend80  <= (in_bytes == 3'd4);
                            r_padding <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    if (r_pend80) begin
                        if (r_wp != 5'(BLOCK_WORDS)) begin
                            r_buf[r_wp[3:0]] <= {PAD_BYTE, 24'h0};
                            r_wp             <= r_wp + 5'd1;
                            r_pend80         <= 1'b0;
                        end
                    end else if (r_wp < 5'(LEN_WORD)) begin
                        r_buf[r_wp[3:0]] <= 32'h0;
                        r_wp             <= r_wp + 5'd1;
                    end
                end
                S_LEN: begin
                    r_buf[4'(LEN_WORD)]     <= r_len[63:32];
                    r_buf[4'(LEN_WORD + 1)] <= r_len[31:0];
                    r_out_last              <= 1'b1;
                end
                S_OUT: begin
                    if (w_out_fire) begin
                        for (int i = 0; i < BLOCK_WORDS; i++) begin
                            r_buf[i] <= 32'h0;
                        end
                        r_wp       <= 5'd0;
                        r_out_last <= 1'b0;
                        if (r_out_last) begin
                            r_index   <= 64'd0;
                            r_len     <= 64'd0;
                            r_padding <= 1'b0;
                            r_in_msg  <= 1'b0;
                        end else begin
                            r_index <= r_index + 64'd1;
                        end
                    end
                end
                default: begin
                    r_wp <= 5'd0;
                end
            endcase
        end
    end

    // Flatten the buffer, word 0 in the top bits.
    always_comb begin
        Data = 512'd0;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            Data[511-32*i -: 32] = r_buf[i];
        end
    end

    assign Index     = r_index;
    assign Operation = r_op;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;

endmodule

// File: tb/tb_sha_pad.sv
// Scoreboard bench for sha_pad: a byte-level padding model predicts every block.
module tb_sha_pad;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [511:0] data;
        logic [63:0]  idx;
        logic         op;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic         in_last;
    logic         in_op;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] Data;
    logic [63:0]  Index;
    logic         Operation;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ready_mode = 1;

    always #5 clk = ~clk;

    sha_pad dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_bytes(in_bytes),
        .in_last(in_last), .in_op(in_op), .in_valid(in_valid), .in_ready(in_ready),
        .Data(Data), .Index(Index), .Operation(Operation), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: message bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit count.
    task automatic push_expected(input bq_t msg, input logic op);
        bq_t         p;
        logic [63:0] bits;
        exp_t        e;
        int          nb;
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            for (int k = 0; k < 64; k++) e.data[511-8*k -: 8] = p[64*b+k];
            e.idx  = 64'(b);
            e.op   = op;
            e.last = (b == nb - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last,
                             input logic op, output bit ok);
        int gap;
        bit hs;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        in_data  = d;
        in_bytes = nb;
        in_last  = last;
        in_op    = op;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input bq_t msg, input logic op);
        int          nw;
        int          nb;
        logic [31:0] w;
        bit          ok;
        bit          all_ok;
        push_expected(msg, op);
        nw = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
        all_ok = 1'b1;
        for (int wi = 0; wi < nw; wi++) begin
            nb = msg.size() - 4 * wi;
            if (nb > 4) nb = 4;
            for (int k = 0; k < 4; k++)
                w[31-8*k -: 8] = (k < nb) ? msg[4*wi+k] : 8'($urandom_range(0, 255));
            send_word(w, 3'(nb), (wi == nw - 1),
                      (wi == 0) ? op : 1'($urandom_range(0, 1)), ok);
            all_ok = all_ok & ok;
        end
        chk("msg_accepted", {511'd0, all_ok}, 512'd1);
    endtask

    function automatic bq_t rand_msg(input int len);
        bq_t m;
        for (int i = 0; i < len; i++) m.push_back(8'($urandom_range(0, 255)));
        return m;
    endfunction

    task automatic wait_drain();
        for (int t = 0; t < 3000; t++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain", 512'(sb.size()), 512'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // out_ready driver: 0 random, 1 held high, otherwise held low.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every transferred block is popped from the scoreboard and compared.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_block: got block Index %0d, expected none", Index);
                end else begin
                    e = sb.pop_front();
                    chk("blk_data", Data, e.data);
                    chk("blk_index", 512'(Index), 512'(e.idx));
                    chk("blk_op", 512'(Operation), 512'(e.op));
                    chk("blk_last", 512'(out_last), 512'(e.last));
                    chk("blk_in_ready_low", 512'(in_ready), 512'd0);
                end
            end
        end
    end

    initial begin : main
        bq_t          m;
        logic [511:0] s_data;
        logic [63:0]  s_idx;
        logic         s_last;
        bit           found;
        bit           ok;
        bit           seen;
        rst = 1'b1; in_data = 32'h0; in_bytes = 3'd0; in_last = 1'b0;
        in_op = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 512'(out_valid), 512'd0);
        chk("rst_in_ready", 512'(in_ready), 512'd0);
        chk("rst_index", 512'(Index), 512'd0);
        chk("rst_out_last", 512'(out_last), 512'd0);
        chk("rst_operation", 512'(Operation), 512'd0);
        chk("rst_data", Data, 512'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_after_rst", 512'(in_ready), 512'd1);
        @(posedge clk);
        #1;

        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b1);
        m = {};
        send_msg(m, 1'b1);
        send_msg(rand_msg(55), 1'b0);
        send_msg(rand_msg(56), 1'b1);
        send_msg(rand_msg(64), 1'b0);
        send_msg(rand_msg(63), 1'b1);
        wait_drain();

        // Output back-pressure: block must hold steady with input blocked.
        ready_mode = 2;
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 1'($urandom_range(0, 1)));
        found = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("stall_valid_seen", 512'(found), 512'd1);
        s_data = Data; s_idx = Index; s_last = out_last;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("stall_data", Data, s_data);
            chk("stall_index", 512'(Index), 512'(s_idx));
            chk("stall_last", 512'(out_last), 512'(s_last));
            chk("stall_valid", 512'(out_valid), 512'd1);
            chk("stall_in_ready", 512'(in_ready), 512'd0);
        end
        @(posedge clk);
        #1;
        ready_mode = 1;
        out_ready  = 1'b1;
        wait_drain();
        send_msg(rand_msg(20), 1'b0);
        wait_drain();

        // Reset after seven words: partial message must vanish.
        for (int i = 0; i < 7; i++) begin
            send_word(32'($urandom()), 3'd4, 1'b0, 1'b1, ok);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 512'(out_valid), 512'd0);
        chk("midrst_data", Data, 512'd0);
        chk("midrst_in_ready", 512'(in_ready), 512'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_in_ready_rise", 512'(in_ready), 512'd1);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("midrst_no_block", 512'(seen), 512'd0);
        @(posedge clk);
        #1;
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0);
        wait_drain();

        ready_mode = 0;
        for (int n = 0; n < 12; n++) begin
            send_msg(rand_msg($urandom_range(0, 150)), 1'($urandom_range(0, 1)));
        end
        ready_mode = 1;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
